// File: rtl/vcounter_if.sv
// rtl/vcounter_if.sv - line-timing inputs and vertical-timing outputs of the vertical counter
// slave: vcounter itself; master: whatever drives the horizontal timing and consumes the outputs.

interface vcounter_if;
   logic       h_tick;
   logic       hbl_n;
   logic       h_sync_n;
   logic [8:0] vcount;
   logic [2:0] scan;
   logic [4:0] row;
   logic       vbl_n;
   logic       v_sync_n;
   logic       frame_start;
   logic       blink;
   logic       comp_blank_n;
   logic       comp_sync_n;

   modport slave (
      input  h_tick, hbl_n, h_sync_n,
      output vcount, scan, row, vbl_n, v_sync_n, frame_start, blink,
             comp_blank_n, comp_sync_n
   );

   modport master (
      output h_tick, hbl_n, h_sync_n,
      input  vcount, scan, row, vbl_n, v_sync_n, frame_start, blink,
             comp_blank_n, comp_sync_n
   );
endinterface

// File: rtl/vcounter.sv
// rtl/vcounter.sv - Apple-1 vertical timing: line counter, vblank/vsync, frame pulse, cursor blink
// Optional feature: define CURSOR_BLINK_EN to build the blink frame counter; otherwise blink is tied to 1.

module vcounter #(
   parameter int V_TOTAL      = 262,
   parameter int V_ACTIVE     = 192,
   parameter int VSYNC_START  = 224,
   parameter int VSYNC_LEN    = 4,
   parameter int BLINK_FRAMES = 16
) (
   input  logic        clk,
   input  logic        mr_n,
   vcounter_if.slave   vif
);

   localparam logic [8:0] LAST_LINE  = 9'(V_TOTAL - 1);
   localparam logic [8:0] ACT_LINES  = 9'(V_ACTIVE);
   localparam logic [9:0] VS_FIRST   = 10'(VSYNC_START);
   localparam logic [9:0] VS_END     = 10'(VSYNC_START + VSYNC_LEN);

   if (V_ACTIVE >= VSYNC_START) begin : g_bad_active
      $error("vcounter: V_ACTIVE (%0d) must be below VSYNC_START (%0d)", V_ACTIVE, VSYNC_START);
   end
   if (V_ACTIVE % 8 != 0) begin : g_bad_rows
      $error("vcounter: V_ACTIVE (%0d) must be a multiple of 8", V_ACTIVE);
   end
   if (VSYNC_START + VSYNC_LEN > V_TOTAL) begin : g_bad_sync
      $error("vcounter: vsync window ends past V_TOTAL (%0d)", V_TOTAL);
   end
   if (V_TOTAL > 512) begin : g_bad_total
      $error("vcounter: V_TOTAL (%0d) exceeds 512", V_TOTAL);
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("vcounter: BLINK_FRAMES (%0d) must be at least 1", BLINK_FRAMES);
   end

   logic [8:0] vcount_q;
   logic [8:0] vcount_nxt;
   logic       wrap;
   logic       vbl_n_q;
   logic       v_sync_n_q;
   logic       frame_start_q;

   assign wrap = vif.h_tick && (vcount_q == LAST_LINE);

   always_comb begin
      vcount_nxt = vcount_q;
      if (wrap)
         vcount_nxt = '0;
      else if (vif.h_tick)
         vcount_nxt = vcount_q + 9'd1;
   end

   // Blanking and sync decode the next count so they change on the same edge as vcount.
   always_ff @(posedge clk or negedge mr_n) begin
      if (!mr_n) begin
         vcount_q      <= '0;
         vbl_n_q       <= 1'b1;
         v_sync_n_q    <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         vcount_q      <= vcount_nxt;
         vbl_n_q       <= (vcount_nxt < ACT_LINES);
         v_sync_n_q    <= !(({1'b0, vcount_nxt} >= VS_FIRST) && ({1'b0, vcount_nxt} < VS_END));
         frame_start_q <= wrap;
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   logic [FC_W-1:0] frame_cnt;
   logic            blink_q;

   always_ff @(posedge clk or negedge mr_n) begin
      if (!mr_n) begin
         frame_cnt <= '0;
         blink_q   <= 1'b1;
      end else if (wrap) begin
         if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            blink_q   <= ~blink_q;
         end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
         end
      end
   end

   assign vif.blink = blink_q;
`else
   assign vif.blink = 1'b1;
`endif

   assign vif.vcount       = vcount_q;
   assign vif.scan         = vcount_q[2:0];
   assign vif.row          = vcount_q[7:3];
   assign vif.vbl_n        = vbl_n_q;
   assign vif.v_sync_n     = v_sync_n_q;
   assign vif.frame_start  = frame_start_q;
   assign vif.comp_blank_n = vif.hbl_n & vbl_n_q;
   assign vif.comp_sync_n  = vif.h_sync_n & v_sync_n_q;

endmodule

// File: tb/tb_vcounter.sv
// tb/tb_vcounter.sv - directed self-checking bench for vcounter (BLINK_FRAMES=2)
// Blink expectations follow CURSOR_BLINK_EN when defined for the build.

module tb_vcounter;
   logic clk;
   logic mr_n;
   int   checks;
   int   errors;

   vcounter_if vif ();

   vcounter #(
      .V_TOTAL      (262),
      .V_ACTIVE     (192),
      .VSYNC_START  (224),
      .VSYNC_LEN    (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk  (clk),
      .mr_n (mr_n),
      .vif  (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n counting edges with h_tick high; returns 1 ns after the last edge with h_tick low.
   task automatic edges(input int n);
      vif.h_tick = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      vif.h_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      mr_n = 1'b0;
      @(negedge clk);
      mr_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      mr_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         vif.h_tick = i[0];
         @(posedge clk);
         #1;
      end
      vif.h_tick = 1'b0;
      checks++; if (vif.vcount !== 9'd0) begin errors++; $display("FAIL reset_vcount got %0d want 0", vif.vcount); end
      checks++; if (vif.vbl_n !== 1'b1) begin errors++; $display("FAIL reset_vbl_n got %b want 1", vif.vbl_n); end
      checks++; if (vif.v_sync_n !== 1'b1) begin errors++; $display("FAIL reset_v_sync_n got %b want 1", vif.v_sync_n); end
      checks++; if (vif.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", vif.frame_start); end
      checks++; if (vif.blink !== 1'b1) begin errors++; $display("FAIL reset_blink got %b want 1", vif.blink); end
      @(negedge clk);
      mr_n = 1'b1;
      @(posedge clk);
      #1;
      edges(5);
      checks++; if (vif.vcount !== 9'd5) begin errors++; $display("FAIL count5_vcount got %0d want 5", vif.vcount); end
      checks++; if (vif.scan !== 3'd5) begin errors++; $display("FAIL count5_scan got %0d want 5", vif.scan); end
      checks++; if (vif.row !== 5'd0) begin errors++; $display("FAIL count5_row got %0d want 0", vif.row); end
   endtask

   task automatic test_blanking();
      do_reset();
      edges(191);
      checks++; if (vif.vcount !== 9'd191) begin errors++; $display("FAIL blank191_vcount got %0d want 191", vif.vcount); end
      checks++; if (vif.vbl_n !== 1'b1) begin errors++; $display("FAIL blank191_vbl_n got %b want 1", vif.vbl_n); end
      checks++; if (vif.row !== 5'd23) begin errors++; $display("FAIL blank191_row got %0d want 23", vif.row); end
      edges(1);
      checks++; if (vif.vcount !== 9'd192) begin errors++; $display("FAIL blank192_vcount got %0d want 192", vif.vcount); end
      checks++; if (vif.vbl_n !== 1'b0) begin errors++; $display("FAIL blank192_vbl_n got %b want 0", vif.vbl_n); end
      checks++; if (vif.scan !== 3'd0) begin errors++; $display("FAIL blank192_scan got %0d want 0", vif.scan); end
      edges(31);
      checks++; if (vif.v_sync_n !== 1'b1) begin errors++; $display("FAIL sync223_v_sync_n got %b want 1", vif.v_sync_n); end
      checks++; if (vif.vbl_n !== 1'b0) begin errors++; $display("FAIL blank223_vbl_n got %b want 0", vif.vbl_n); end
   endtask

   task automatic test_sync_window();
      edges(1);
      checks++; if (vif.vcount !== 9'd224) begin errors++; $display("FAIL sync224_vcount got %0d want 224", vif.vcount); end
      checks++; if (vif.v_sync_n !== 1'b0) begin errors++; $display("FAIL sync224_v_sync_n got %b want 0", vif.v_sync_n); end
      edges(1);
      vif.hbl_n = 1'b1;
      vif.h_sync_n = 1'b0;
      #1;
      checks++; if (vif.comp_sync_n !== 1'b0) begin errors++; $display("FAIL sync225_comp_sync_n got %b want 0", vif.comp_sync_n); end
      checks++; if (vif.comp_blank_n !== 1'b0) begin errors++; $display("FAIL sync225_comp_blank_n got %b want 0", vif.comp_blank_n); end
      vif.h_sync_n = 1'b1;
      #1;
      checks++; if (vif.comp_sync_n !== 1'b0) begin errors++; $display("FAIL sync225_vs_only got %b want 0", vif.comp_sync_n); end
      edges(2);
      checks++; if (vif.v_sync_n !== 1'b0) begin errors++; $display("FAIL sync227_v_sync_n got %b want 0", vif.v_sync_n); end
      edges(1);
      checks++; if (vif.vcount !== 9'd228) begin errors++; $display("FAIL sync228_vcount got %0d want 228", vif.vcount); end
      checks++; if (vif.v_sync_n !== 1'b1) begin errors++; $display("FAIL sync228_v_sync_n got %b want 1", vif.v_sync_n); end
      checks++; if (vif.comp_sync_n !== 1'b1) begin errors++; $display("FAIL sync228_comp_sync_n got %b want 1", vif.comp_sync_n); end
      vif.h_sync_n = 1'b0;
      #1;
      checks++; if (vif.comp_sync_n !== 1'b0) begin errors++; $display("FAIL sync228_hs_only got %b want 0", vif.comp_sync_n); end
      vif.h_sync_n = 1'b1;
   endtask

   task automatic test_wrap();
      edges(33);
      checks++; if (vif.vcount !== 9'd261) begin errors++; $display("FAIL wrap261_vcount got %0d want 261", vif.vcount); end
      checks++; if (vif.frame_start !== 1'b0) begin errors++; $display("FAIL wrap261_frame_start got %b want 0", vif.frame_start); end
      edges(1);
      checks++; if (vif.vcount !== 9'd0) begin errors++; $display("FAIL wrap_vcount got %0d want 0", vif.vcount); end
      checks++; if (vif.vbl_n !== 1'b1) begin errors++; $display("FAIL wrap_vbl_n got %b want 1", vif.vbl_n); end
      checks++; if (vif.v_sync_n !== 1'b1) begin errors++; $display("FAIL wrap_v_sync_n got %b want 1", vif.v_sync_n); end
      checks++; if (vif.frame_start !== 1'b1) begin errors++; $display("FAIL wrap_frame_start got %b want 1", vif.frame_start); end
      checks++; if (vif.comp_blank_n !== 1'b1) begin errors++; $display("FAIL wrap_comp_blank_n got %b want 1", vif.comp_blank_n); end
      @(posedge clk);
      #1;
      checks++; if (vif.frame_start !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width got %b want 0", vif.frame_start); end
      repeat (9) @(posedge clk);
      #1;
      checks++; if (vif.vcount !== 9'd0) begin errors++; $display("FAIL hold_vcount got %0d want 0", vif.vcount); end
      checks++; if (vif.frame_start !== 1'b0) begin errors++; $display("FAIL hold_frame_start got %b want 0", vif.frame_start); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         vif.h_tick = (i % 2 == 0);
         @(posedge clk);
         #1;
      end
      vif.h_tick = 1'b0;
      checks++; if (vif.vcount !== 9'd3) begin errors++; $display("FAIL alt_tick_vcount got %0d want 3", vif.vcount); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      edges(226);
      checks++; if (vif.v_sync_n !== 1'b0) begin errors++; $display("FAIL mid226_v_sync_n got %b want 0", vif.v_sync_n); end
      #3;
      mr_n = 1'b0;
      #1;
      checks++; if (vif.vcount !== 9'd0) begin errors++; $display("FAIL midrst_vcount got %0d want 0", vif.vcount); end
      checks++; if (vif.v_sync_n !== 1'b1) begin errors++; $display("FAIL midrst_v_sync_n got %b want 1", vif.v_sync_n); end
      checks++; if (vif.vbl_n !== 1'b1) begin errors++; $display("FAIL midrst_vbl_n got %b want 1", vif.vbl_n); end
      #19;
      mr_n = 1'b1;
      @(posedge clk);
      #1;
      edges(3);
      checks++; if (vif.vcount !== 9'd3) begin errors++; $display("FAIL resume_vcount got %0d want 3", vif.vcount); end
   endtask

   task automatic test_blink();
      logic [3:0] want;
`ifdef CURSOR_BLINK_EN
      want = 4'b1001;
`else
      want = 4'b1111;
`endif
      do_reset();
      for (int f = 0; f < 4; f++) begin
         edges(262);
         checks++;
         if (vif.blink !== want[3-f]) begin
            errors++;
            $display("FAIL blink_frame%0d got %b want %b", f + 1, vif.blink, want[3-f]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mr_n = 1'b0;
      vif.h_tick = 1'b0;
      vif.hbl_n = 1'b1;
      vif.h_sync_n = 1'b1;
      test_reset();
      test_blanking();
      test_sync_window();
      test_wrap();
      test_back_to_back();
      test_mid_reset();
      test_blink();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
